// File: rtl/image_rom_arbiter.sv
// image_rom_arbiter: shares the single-port Image block RAM between the VGA fetch path (port 0)
// and the sprite/game path (port 1). Build option IMG_ARB_STARVE_GUARD_EN adds the port-1 starvation guard.
module image_rom_arbiter #(
    parameter int unsigned AW         = 19,
    parameter int unsigned DW         = 12,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          rom_wea,
    output logic [AW-1:0] rom_addra,
    output logic [DW-1:0] rom_dina,
    input  logic [DW-1:0] rom_douta
);
    localparam int unsigned TAG_D = RD_LAT + 1;

    if (RD_LAT < 1 || RD_LAT > 3 || STARVE_MAX < 1) begin : g_bad_param
        $error("image_rom_arbiter: RD_LAT must be 1..3 and STARVE_MAX at least 1");
    end

`ifdef IMG_ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_FORCE1 = 1'b1
    } state_e;

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_starve_cnt;
    logic [CW-1:0] w_starve_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_NORMAL;
            r_starve_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    // Counts consecutive denied port-1 cycles, saturating at STARVE_MAX
    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!p1_req || p1_gnt) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != CW'(STARVE_MAX)) begin
            w_starve_nxt = r_starve_cnt + CW'(1);
        end
    end

    // Enter FORCE1 in the same cycle the counter lands on STARVE_MAX so the forced slot
    // follows exactly STARVE_MAX denials
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: if (w_starve_nxt == CW'(STARVE_MAX)) w_state_nxt = ST_FORCE1;
            ST_FORCE1: w_state_nxt = ST_NORMAL;
            default:   w_state_nxt = ST_NORMAL;
        endcase
    end

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        case (r_state)
            ST_FORCE1: p1_gnt = p1_req;
            default: begin
                p0_gnt = p0_req;
                p1_gnt = p1_req & ~p0_req;
            end
        endcase
    end
`else
    always_comb begin
        p0_gnt = p0_req;
        p1_gnt = p1_req & ~p0_req;
    end
`endif

    logic             w_rd0;
    logic             w_rd1;
    logic [TAG_D-1:0] r_v0;
    logic [TAG_D-1:0] r_v1;
    logic             r_wea;
    logic [AW-1:0]    r_addra;
    logic [DW-1:0]    r_dina;

    assign w_rd0 = p0_gnt;
    assign w_rd1 = p1_gnt & ~p1_we;

    // Memory-side issue register; address holds when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else if (p0_gnt) begin
            r_wea   <= 1'b0;
            r_addra <= p0_addr;
            r_dina  <= '0;
        end else if (p1_gnt) begin
            r_wea   <= p1_we;
            r_addra <= p1_addr;
            r_dina  <= p1_wdata;
        end else begin
            r_wea   <= 1'b0;
        end
    end

    // Per-owner valid shift registers form the {valid, owner} tag pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0 <= '0;
            r_v1 <= '0;
        end else begin
            r_v0 <= {r_v0[TAG_D-2:0], w_rd0};
            r_v1 <= {r_v1[TAG_D-2:0], w_rd1};
        end
    end

    assign p0_rvalid = r_v0[TAG_D-1];
    assign p1_rvalid = r_v1[TAG_D-1];
    assign p0_rdata  = rom_douta;
    assign p1_rdata  = rom_douta;
    assign rom_wea   = r_wea;
    assign rom_addra = r_addra;
    assign rom_dina  = r_dina;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Self-checking bench for image_rom_arbiter with a behavioural write-first block RAM and a
// scoreboard of expected read returns. Honours IMG_ARB_STARVE_GUARD_EN for contention expectations.
module tb_image_rom_arbiter;
    localparam int unsigned AW         = 19;
    localparam int unsigned DW         = 12;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned STARVE_MAX = 8;
`ifdef IMG_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req;
    logic [AW-1:0] p0_addr;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;
    logic          p1_req;
    logic          p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;
    logic          rom_wea;
    logic [AW-1:0] rom_addra;
    logic [DW-1:0] rom_dina;
    logic [DW-1:0] rom_douta;

    always #5 clk = ~clk;

    image_rom_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .rom_wea(rom_wea), .rom_addra(rom_addra), .rom_dina(rom_dina),
        .rom_douta(rom_douta)
    );

    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        return a[DW-1:0] ^ DW'(a[AW-1:DW]) ^ DW'(12'h5A5);
    endfunction

    // Block RAM model: stored word is XORed with a per-address seed so unwritten cells read a known pattern
    bit   [DW-1:0] mem [2**AW];
    logic [DW-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (rom_wea) mem[rom_addra] <= rom_dina ^ seed(rom_addra);
        rd_pipe[0] <= rom_wea ? rom_dina : (mem[rom_addra] ^ seed(rom_addra));
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign rom_douta = rd_pipe[RD_LAT-1];

    typedef struct {
        int unsigned   due;
        logic          owner;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t       sb[$];
    logic [DW-1:0] shadow [logic [AW-1:0]];
    int unsigned   cyc;
    int unsigned   n_chk;
    int unsigned   n_pass;
    logic          exp_wea;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dina;

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        return shadow.exists(a) ? shadow[a] : seed(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, expv);
    endtask

    // One clock of stimulus; g0/g1 are the grants the arbiter must give for these inputs
    task automatic step(input logic r0, input logic [AW-1:0] a0,
                        input logic r1, input logic we1, input logic [AW-1:0] a1,
                        input logic [DW-1:0] wd1, input logic g0, input logic g1);
        rd_exp_t e;
        p0_req = r0; p0_addr = a0;
        p1_req = r1; p1_we = we1; p1_addr = a1; p1_wdata = wd1;
        @(negedge clk);
        chk("p0_gnt", 32'(p0_gnt), 32'(g0));
        chk("p1_gnt", 32'(p1_gnt), 32'(g1));
        chk("rom_wea", 32'(rom_wea), 32'(exp_wea));
        chk("rom_addra", 32'(rom_addra), 32'(exp_addr));
        if (exp_wea) chk("rom_dina", 32'(rom_dina), 32'(exp_dina));
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rvalid", 32'({p1_rvalid, p0_rvalid}), e.owner ? 32'd2 : 32'd1);
            if (e.owner) chk("p1_rdata", 32'(p1_rdata), 32'(e.data));
            else         chk("p0_rdata", 32'(p0_rdata), 32'(e.data));
        end else begin
            chk("rvalid_idle", 32'({p1_rvalid, p0_rvalid}), 32'd0);
        end
        exp_wea = 1'b0;
        if (g0) begin
            exp_addr = a0;
            sb.push_back('{due: cyc + RD_LAT + 1, owner: 1'b0, data: exp_rd(a0)});
        end else if (g1) begin
            exp_addr = a1;
            exp_wea  = we1;
            if (we1) begin
                exp_dina   = wd1;
                shadow[a1] = wd1;
            end else begin
                sb.push_back('{due: cyc + RD_LAT + 1, owner: 1'b1, data: exp_rd(a1)});
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < int'(n); i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p0_rvalid"}, 32'(p0_rvalid), 32'd0);
        chk({tag, "_p1_rvalid"}, 32'(p1_rvalid), 32'd0);
        chk({tag, "_gnt"}, 32'({p1_gnt, p0_gnt}), 32'd0);
        chk({tag, "_rom_wea"}, 32'(rom_wea), 32'd0);
        chk({tag, "_rom_addra"}, 32'(rom_addra), 32'd0);
        chk({tag, "_rom_dina"}, 32'(rom_dina), 32'd0);
    endtask

    initial begin
        logic g1;
        n_chk = 0; n_pass = 0; cyc = 0;
        exp_wea = 1'b0; exp_addr = '0; exp_dina = '0;
        rst_n = 1'b0;
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Port-0 descending sweep
        for (int a = 262252; a >= 262241; a--) step(1'b1, AW'(a), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Port-1 write then read-back of the same address
        step(1'b0, '0, 1'b1, 1'b1, AW'(5), 12'hABC, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, AW'(5), '0, 1'b0, 1'b1);
        idle(3);

        // Both ports contend for 20 cycles
        for (int i = 0; i < 20; i++) begin
            g1 = GUARD && (((i + 1) % int'(STARVE_MAX + 1)) == 0);
            step(1'b1, AW'(1000 + i), 1'b1, 1'b0, AW'(50), '0, ~g1, g1);
        end
        idle(3);

        // Interleaved owners return in grant order with no bubbles
        step(1'b1, AW'(1), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, AW'(2), '0, 1'b0, 1'b1);
        step(1'b1, AW'(3), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(3);

        // Reset while two reads are in flight discards them
        step(1'b1, AW'(10), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        step(1'b1, AW'(11), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        p0_req = 1'b0; p1_req = 1'b0; p0_addr = '0; p1_addr = '0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        exp_wea = 1'b0; exp_addr = '0;
        @(negedge clk);
        @(posedge clk);
        cyc++;
        #1;
        rst_n = 1'b1;
        idle(3);
        step(1'b1, AW'(7), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
